// File: rtl/cache_pkg.sv
// Shared geometry, address-field positions and controller state encoding
// for the instruction cache and its line-fill unit.
package cache_pkg;

  localparam int SETS       = 64;
  localparam int WORDS      = 8;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 3;
  localparam int TAG_W      = 21;
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_FILL   = 2'd3
  } icache_state_t;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch, data-array and line-fill signals of the instruction-cache controller.
// slave = controller side, master = CPU / data array / fill unit side.
interface icache_ctrl_if;

  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        flush;
  logic [8:0]  data_rd_addr;
  logic [31:0] data_rd_data;
  logic        fill_start;
  logic [31:0] fill_addr;
  logic        fill_done;

  modport slave (
    input  cpu_req, cpu_addr, flush, data_rd_data, fill_done,
    output cpu_rdata, cpu_stall, data_rd_addr, fill_start, fill_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, data_rd_data, fill_done,
    input  cpu_rdata, cpu_stall, data_rd_addr, fill_start, fill_addr
  );

endinterface

// File: rtl/icache_tag_ram.sv
// Tag store and valid bits for the direct-mapped instruction cache.
// Asynchronous read, synchronous write; flush clears every valid bit in one cycle.
module icache_tag_ram
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush_i,
  input  index_t rd_index_i,
  output tag_t   rd_tag_o,
  output logic   rd_valid_o,
  input  logic   we_i,
  input  index_t wr_index_i,
  input  tag_t   wr_tag_i
);

  logic [SETS-1:0] valid_q;
  tag_t            tag_q [SETS];

  // flush has priority so a line being installed while flushing stays invalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction-cache controller: hit check, miss stall, line-fill handoff.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  icache_ctrl_if.slave        bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  icache_state_t         state_q, state_d;
  logic [31:INDEX_LSB]   miss_line_q, miss_line_d;

  tag_t   cur_tag, rd_tag;
  index_t cur_index;
  logic   rd_valid, hit;
  logic   tag_we, lookup_hit, lookup_miss;
  logic   unused_addr_bits;

  assign cur_tag   = bus.cpu_addr[TAG_LSB +: TAG_W];
  assign cur_index = bus.cpu_addr[INDEX_LSB +: INDEX_W];
  assign hit       = rd_valid && (rd_tag == cur_tag);

  assign unused_addr_bits = ^bus.cpu_addr[OFFSET_LSB-1:0];

  icache_tag_ram u_tag_ram (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.flush),
    .rd_index_i (cur_index),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .we_i       (tag_we),
    .wr_index_i (miss_line_q[INDEX_LSB +: INDEX_W]),
    .wr_tag_i   (miss_line_q[TAG_LSB +: TAG_W])
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOOKUP;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    miss_line_d    = miss_line_q;
    bus.cpu_stall  = 1'b0;
    bus.cpu_rdata  = '0;
    bus.fill_start = 1'b0;
    tag_we         = 1'b0;
    lookup_hit     = 1'b0;
    lookup_miss    = 1'b0;
    case (state_q)
      S_LOOKUP: begin
        if (bus.cpu_req) begin
          if (hit) begin
            bus.cpu_rdata = bus.data_rd_data;
            lookup_hit    = 1'b1;
          end else begin
            bus.cpu_stall = 1'b1;
            miss_line_d   = bus.cpu_addr[31:INDEX_LSB];
            lookup_miss   = 1'b1;
            state_d       = S_REQ;
          end
        end
      end
      S_REQ: begin
        bus.cpu_stall  = 1'b1;
        bus.fill_start = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        bus.cpu_stall = 1'b1;
        if (bus.fill_done) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        bus.cpu_stall = 1'b1;
        tag_we        = 1'b1;
        state_d       = S_LOOKUP;
      end
      default: state_d = S_LOOKUP;
    endcase
  end

  // fill unit samples this every cycle, so it is driven straight from the latched line
  assign bus.fill_addr    = {miss_line_q, {INDEX_LSB{1'b0}}};
  assign bus.data_rd_addr = {cur_index, bus.cpu_addr[OFFSET_LSB +: OFFSET_W]};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed scoreboard bench for icache_ctrl: misses, hits, conflicts, flush-in-fill,
// spurious fill_done and reset during a fill.
module tb_icache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_ctrl_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // data array model: each word encodes its own {index, offset} address
  assign bus.data_rd_data = {16'hC0DE, 7'd0, bus.data_rd_addr};

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] exp_q  [$];
  logic [31:0] fill_q [$];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {16'hC0DE, 7'd0, a[10:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed event missing, expected event", tag);
  endtask

  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
`endif
  endtask

  // One fetch: drives the request, plays the fill unit, and scores the served word.
  task automatic fetch(input logic [31:0] addr, input bit exp_miss, input int lat,
                       input bit flush_in_fill);
    int          stalls = 0;
    int          fs_cyc = -1;
    int          done_cyc = -1;
    bit          prev_fs = 1'b0;
    bit          flushed = 1'b0;
    bit          served = 1'b0;
    logic [31:0] cur_line = '0;
    logic [31:0] want;
    int          exp_stalls;
    exp_stalls = exp_miss ? ((flush_in_fill ? 2 : 1) * (lat + 3)) : 0;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    exp_q.push_back(exp_word(addr));
    if (exp_miss) fill_q.push_back({addr[31:5], 5'd0});
    for (int cyc = 0; cyc < 200 && !served; cyc++) begin
      #1;
      if (bus.fill_start) begin
        chk("fill_start_back_to_back", {31'd0, prev_fs}, 32'd0);
        if (fill_q.size() == 0) fail_now("unexpected_fill_start");
        else begin
          cur_line = fill_q.pop_front();
          chk("fill_addr_at_start", bus.fill_addr, cur_line);
        end
        fs_cyc = cyc;
        exp_misses++;
      end else if (fs_cyc >= 0 && done_cyc < 0) begin
        chk("fill_addr_held", bus.fill_addr, cur_line);
      end
      if (fs_cyc >= 0 && done_cyc < 0 && cyc == fs_cyc + lat) begin
        bus.fill_done = 1'b1;
        done_cyc = cyc;
      end else if (done_cyc >= 0 && cyc == done_cyc + 1 && flush_in_fill && !flushed) begin
        bus.flush = 1'b1;
        flushed = 1'b1;
        fill_q.push_back({addr[31:5], 5'd0});
        fs_cyc = -1;
        done_cyc = -1;
      end
      prev_fs = bus.fill_start;
      if (!bus.cpu_stall) begin
        if (exp_q.size() == 0) fail_now("scoreboard_empty");
        else begin
          want = exp_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, want);
        end
        chk("stall_cycles", stalls, exp_stalls);
        chk_stats();
        exp_hits++;
        served = 1'b1;
      end else begin
        stalls++;
      end
      @(negedge clk);
      bus.fill_done = 1'b0;
      bus.flush     = 1'b0;
    end
    if (!served) fail_now("fetch_timeout");
    if (fill_q.size() != 0) begin
      fail_now("fill_never_started");
      fill_q.delete();
    end
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    bit found;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.flush     = 1'b0;
    bus.fill_done = 1'b0;
    #1;
    chk("reset_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("reset_fill_start", {31'd0, bus.fill_start}, 32'd0);
    chk("reset_fill_addr", bus.fill_addr, 32'd0);
    chk("reset_rdata", bus.cpu_rdata, 32'd0);
    chk_stats();
    @(negedge clk);
    rst = 1'b1;

    fetch(32'h0000_0040, 1'b1, 4, 1'b0);
    fetch(32'h0000_005C, 1'b0, 1, 1'b0);

    @(negedge clk);
    bus.cpu_addr = 32'h0000_005C;
    #1;
    chk("data_rd_addr", {23'd0, bus.data_rd_addr}, 32'h0000_0017);
    chk("idle_rdata", bus.cpu_rdata, 32'd0);
    chk("idle_stall", {31'd0, bus.cpu_stall}, 32'd0);

    // fill_done while idle in LOOKUP must not start anything
    @(negedge clk);
    bus.fill_done = 1'b1;
    #1;
    chk("spurious_done_fill_start", {31'd0, bus.fill_start}, 32'd0);
    @(negedge clk);
    bus.fill_done = 1'b0;
    #1;
    chk("spurious_done_fill_start_next", {31'd0, bus.fill_start}, 32'd0);
    chk("spurious_done_stall", {31'd0, bus.cpu_stall}, 32'd0);
    fetch(32'h0000_0044, 1'b0, 1, 1'b0);

    // conflict on index 2
    fetch(32'h0000_0840, 1'b1, 2, 1'b0);
    fetch(32'h0000_0040, 1'b1, 1, 1'b0);
    fetch(32'h0000_0848, 1'b1, 3, 1'b0);
    fetch(32'h0000_0850, 1'b0, 1, 1'b0);

    // flush during FILL forces a refetch
    fetch(32'h0000_0200, 1'b1, 2, 1'b1);
    fetch(32'h0000_0204, 1'b0, 1, 1'b0);

    // reset while waiting for a fill
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0100;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.fill_start) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) fail_now("rst_test_fill_start");
    chk("rst_test_fill_addr", bus.fill_addr, 32'h0000_0100);
    @(negedge clk);
    #1;
    chk("rst_test_wait_stall", {31'd0, bus.cpu_stall}, 32'd1);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    chk("rst_mid_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst_mid_fill_start", {31'd0, bus.fill_start}, 32'd0);
    chk("rst_mid_fill_addr", bus.fill_addr, 32'd0);
    chk("rst_mid_rdata", bus.cpu_rdata, 32'd0);
    chk_stats();
    @(negedge clk);
    rst = 1'b1;
    fetch(32'h0000_005C, 1'b1, 2, 1'b0);
    fetch(32'h0000_0058, 1'b0, 1, 1'b0);

    @(negedge clk);
    #1;
    chk_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
